// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receiver: logic-level constants and the receive FSM states.
package uart_receiver_pkg;

  localparam logic YES  = 1'b1;
  localparam logic NO   = 1'b0;
  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } rx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter that saturates at zero; zero_o marks each bit-period sample point.
module uart_bit_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a one-deep valid/ready output register.
// Define UART_PARITY_EN to receive 8E1 frames and report parity errors.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int unsigned CLK_HZ = 27000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       character_ready,
  output logic       character_valid,
  output logic [7:0] character_byte,
  output logic       framing_error,
  output logic       overrun_error,
  output logic       parity_error
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned CntW         = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullLoad = CntW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 8) begin : g_baud_check
    $error("uart_receiver: CLK_HZ/BAUD must be at least 8");
  end

  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e       state_q, state_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_bad_q, par_bad_d;
  logic            timer_load, timer_zero;
  logic [CntW-1:0] timer_val;
  logic            byte_done, load_out;
  logic            valid_q, valid_d;
  logic [7:0]      byte_q, byte_d;
  logic            fe_q, fe_d, oe_q, oe_d;
`ifdef UART_PARITY_EN
  logic            pe_q, pe_d;
`endif

  uart_bit_timer #(
    .Width(CntW)
  ) u_bit_timer (
    .clk_i     (clk),
    .reset_i   (reset),
    .load_i    (timer_load),
    .load_val_i(timer_val),
    .zero_o    (timer_zero)
  );

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    timer_load = NO;
    timer_val  = FullLoad;
    byte_done  = NO;
    fe_d       = NO;
`ifdef UART_PARITY_EN
    pe_d       = NO;
`endif
    unique case (state_q)
      StIdle: begin
        if (rx_prev_q == HIGH && rx_s2_q == LOW) begin
          timer_load = YES;
          timer_val  = HalfLoad;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (timer_zero) begin
          if (rx_s2_q == LOW) begin
            timer_load = YES;
            bit_idx_d  = '0;
            par_bad_d  = NO;
            state_d    = StData;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (timer_zero) begin
          timer_load = YES;
          shift_d    = {rx_s2_q, shift_q[7:1]};
          bit_idx_d  = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
      StParity: begin
`ifdef UART_PARITY_EN
        if (timer_zero) begin
          timer_load = YES;
          if (^{shift_q, rx_s2_q}) begin
            pe_d      = YES;
            par_bad_d = YES;
          end
          state_d = StStop;
        end
`else
        state_d = StIdle;
`endif
      end
      StStop: begin
        if (timer_zero) begin
          if (rx_s2_q == HIGH) begin
            byte_done = !par_bad_q;
            state_d   = StIdle;
          end else begin
            fe_d    = YES;
            state_d = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        // A held-low break line must not re-trigger a frame until it returns high.
        if (rx_s2_q == HIGH) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    load_out = byte_done && (!valid_q || character_ready);
    byte_d   = load_out ? shift_q : byte_q;
    oe_d     = byte_done && valid_q && !character_ready;
    if (load_out) begin
      valid_d = YES;
    end else if (valid_q && character_ready) begin
      valid_d = NO;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1_q   <= HIGH;
      rx_s2_q   <= HIGH;
      rx_prev_q <= HIGH;
      state_q   <= StIdle;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_bad_q <= NO;
      valid_q   <= NO;
      byte_q    <= '0;
      fe_q      <= NO;
      oe_q      <= NO;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      valid_q   <= valid_d;
      byte_q    <= byte_d;
      fe_q      <= fe_d;
      oe_q      <= oe_d;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pe_q <= NO;
    end else begin
      pe_q <= pe_d;
    end
  end
  assign parity_error = pe_q;
`else
  assign parity_error = LOW;
`endif

  assign character_valid = valid_q;
  assign character_byte  = byte_q;
  assign framing_error   = fe_q;
  assign overrun_error   = oe_q;

endmodule
